// File: rtl/dwisehart_grey_capture.sv
// Gray-bus capture: synchronizes an async ring-counter Gray bus, decodes it and
// counts its advance per 2^GATE_LOG2-cycle gate window. Define GREY_ERR_CHECK_EN to build ERR.
module dwisehart_grey_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_LOG2   = 8,
  parameter int ACC_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] GREY_IN,
  output logic [WIDTH-1:0] BIN,
  output logic [ACC_W-1:0] DELTA,
  output logic             VALID,
  output logic             ERR
);

  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

  typedef enum logic {PRIME, RUN} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]     g_s, bin_d, step;
  logic [ACC_W-1:0]     diff, acc, acc_sat;
  logic [ACC_W:0]       sum;
  logic [GATE_LOG2-1:0] gate_cnt;
  logic [PW-1:0]        prime_cnt;
  logic                 run_acc, win_close;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= GREY_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(g_s >> i);
  end

  // Modulo subtraction makes the top-of-range wrap count as a single step.
  assign step    = bin_d - BIN;
  assign diff    = ACC_W'(step);
  assign sum     = {1'b0, acc} + {1'b0, diff};
  assign acc_sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= PRIME;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!EN)                                          state_nxt = PRIME;
    else if (state == PRIME && prime_cnt == PRIME_LAST) state_nxt = RUN;
  end

  // EN low wins over the terminal cycle, so a dropped window never strobes.
  always_comb begin
    run_acc   = (state == RUN) && EN;
    win_close = run_acc && (&gate_cnt);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BIN       <= '0;
      DELTA     <= '0;
      VALID     <= 1'b0;
      acc       <= '0;
      gate_cnt  <= '0;
      prime_cnt <= '0;
    end else begin
      BIN   <= bin_d;
      VALID <= win_close;
      if (state == PRIME && EN) begin
        if (prime_cnt != PRIME_LAST) prime_cnt <= prime_cnt + 1'b1;
      end else begin
        prime_cnt <= '0;
      end
      if (win_close) begin
        DELTA    <= acc_sat;
        acc      <= '0;
        gate_cnt <= '0;
      end else if (run_acc) begin
        acc      <= acc_sat;
        gate_cnt <= gate_cnt + 1'b1;
      end else begin
        acc      <= '0;
        gate_cnt <= '0;
      end
    end
  end

`ifdef GREY_ERR_CHECK_EN
  logic [WIDTH-1:0] g_prev;
  logic             viol, viol_now, err_q;

  // More than one bit flipping between samples means the ring outran CLK.
  assign viol_now = run_acc && ($countones(g_s ^ g_prev) > 1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      g_prev <= '0;
      viol   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      g_prev <= g_s;
      if (win_close) begin
        err_q <= viol | viol_now;
        viol  <= 1'b0;
      end else if (run_acc) begin
        viol  <= viol | viol_now;
      end else begin
        viol  <= 1'b0;
      end
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dwisehart_grey_capture.sv
// Directed bench for dwisehart_grey_capture with a 16-cycle gate window.
module tb_dwisehart_grey_capture;

  localparam int W = 8;
  localparam int A = 16;
`ifdef GREY_ERR_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         clk, rst_n, en, valid, err;
  logic [W-1:0] grey_in, bin;
  logic [A-1:0] delta;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [W-1:0] grey;
    logic [W-1:0] bin;
  } vec_t;

  vec_t vecs[8];

  dwisehart_grey_capture #(
    .WIDTH(W), .SYNC_STAGES(2), .GATE_LOG2(4), .ACC_W(A)
  ) dut (
    .CLK(clk), .RST(rst_n), .EN(en), .GREY_IN(grey_in),
    .BIN(bin), .DELTA(delta), .VALID(valid), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 200);
    if (!valid) begin
      total++;
      $display("FAIL valid_timeout: got no VALID in %0d cycles, required one", n);
    end
  endtask

  task automatic do_reset(input logic [W-1:0] g, input logic e);
    rst_n   = 1'b0;
    grey_in = g;
    en      = e;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int saw;
    logic [W-1:0] b;

    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'h5A, 8'h6C};
    vecs[2] = '{8'h01, 8'h01};
    vecs[3] = '{8'h03, 8'h02};
    vecs[4] = '{8'h02, 8'h03};
    vecs[5] = '{8'h80, 8'hFF};
    vecs[6] = '{8'hFF, 8'hAA};
    vecs[7] = '{8'hC0, 8'h80};

    // Reset hold, then decode latency after release
    rst_n = 1'b0; en = 1'b0; grey_in = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_bin", bin, 0);
    chk("rst_delta", delta, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("bin_before_latency", bin, 0);
    @(negedge clk);
    chk("bin_after_release", bin, 8'h6C);

    // Decode table, EN low
    for (int i = 0; i < 8; i++) begin
      grey_in = vecs[i].grey;
      repeat (3) @(negedge clk);
      chk($sformatf("decode_%0d", i), bin, vecs[i].bin);
    end

    // Static bus: first VALID 19 cycles after release, then every 16
    do_reset(8'h00, 1'b1);
    wait_valid(n);
    chk("static_first_gap", n, 19);
    chk("static_delta0", delta, 0);
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      chk("static_gap", n, 16);
      chk("static_delta", delta, 0);
    end

    // One Gray step every 2 cycles
    do_reset(8'h00, 1'b1);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          grey_in = gray(8'(i));
          repeat (2) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_valid(n);
          chk("step2_delta", delta, 8);
          chk("step2_err", err, 0);
        end
      end
    join

    // Violation, then EN dropped mid-window
    do_reset(8'h00, 1'b1);
    wait_valid(n);
    chk("viol_pre_delta", delta, 0);
    repeat (5) @(negedge clk);
    grey_in = 8'h03;
    wait_valid(n);
    chk("viol_delta", delta, 2);
    chk("viol_err", err, 32'(ERR_ON));
    repeat (3) @(negedge clk);
    grey_in = 8'h02;
    wait_valid(n);
    chk("viol_after_delta", delta, 1);
    chk("viol_after_err", err, 0);
    repeat (4) @(negedge clk);
    grey_in = 8'h0C;
    repeat (4) @(negedge clk);
    en  = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) grey_in = 8'h0D;
      if (valid) saw++;
    end
    chk("en_off_no_valid", saw, 0);
    chk("en_off_delta_held", delta, 1);
    chk("en_off_err_held", err, 0);
    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 6) grey_in = 8'h0F;
      if (n == 8) grey_in = 8'h0E;
    end while (!valid && n < 60);
    chk("reen_gap", n, 19);
    chk("reen_delta", delta, 2);
    chk("reen_err", err, 0);

    // Wrap through 0xFF -> 0x00 inside one window
    do_reset(gray(8'hF8), 1'b1);
    wait_valid(n);
    chk("wrap_pre_delta", delta, 0);
    repeat (14) @(negedge clk);
    b = 8'hF8;
    for (int i = 0; i < 16; i++) begin
      b++;
      grey_in = gray(b);
      @(negedge clk);
    end
    wait_valid(n);
    chk("wrap_delta", delta, 16);
    chk("wrap_bin", bin, 8'h08);
    chk("wrap_err", err, 0);

    // Asynchronous reset mid-window
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bin", bin, 0);
    chk("async_delta", delta, 0);
    chk("async_valid", valid, 0);
    chk("async_err", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
